tick_period_meter: RTL and testbench

Receive side of the periodic tick produced by the generator's modulo counter: samples a single-cycle `tick` pulse stream and measures the interval between consecutive ticks in clock cycles. Reports each measured period with a one-cycle strobe, flags loss of ticks (timeout), and optionally reports lock when the period is stable. Sits downstream of the modulo counter's `zero` output; used for self-check and by the control logic.

---
 rtl/generator_pkg.sv | 12 +
 rtl/tick_lock_tracker.sv | 65 ++++++
 rtl/tick_period_meter.sv | 101 ++++++++++
 tb/tb_tick_period_meter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/generator_pkg.sv
// Shared types and default sizing for the tick generator / period meter pair.
package generator_pkg;

    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned LOCK_COUNT_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } meas_state_e;

endpackage : generator_pkg

// File: rtl/tick_lock_tracker.sv
// Tracks consecutive identical tick periods and raises locked once LOCK_COUNT
// equal measurements in a row have been seen. Inputs are next-cycle values.
module tick_lock_tracker #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period,
    input  logic             period_vld,
    input  logic             timeout,
    output logic             locked
);

    localparam int unsigned MATCH_W = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(LOCK_COUNT - 1);

    logic [CNT_W-1:0]   prev, prev_nxt;
    logic               have_prev, have_prev_nxt;
    logic [MATCH_W-1:0] match, match_nxt;
    logic [MATCH_W-1:0] match_inc;
    logic               locked_nxt;

    // Match count saturates at the lock target so locked persists while stable.
    always_comb begin
        prev_nxt      = prev;
        have_prev_nxt = have_prev;
        match_nxt     = match;
        locked_nxt    = locked;
        match_inc     = (match == MATCH_TGT) ? match : MATCH_W'(match + MATCH_W'(1));

        if (timeout) begin
            have_prev_nxt = 1'b0;
            match_nxt     = '0;
            locked_nxt    = 1'b0;
        end else if (period_vld) begin
            prev_nxt      = period;
            have_prev_nxt = 1'b1;
            if (have_prev && (period == prev)) begin
                match_nxt = match_inc;
                if (match_inc == MATCH_TGT) begin
                    locked_nxt = 1'b1;
                end
            end else begin
                match_nxt  = '0;
                locked_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            have_prev <= 1'b0;
            match     <= '0;
            locked    <= 1'b0;
        end else begin
            prev      <= prev_nxt;
            have_prev <= have_prev_nxt;
            match     <= match_nxt;
            locked    <= locked_nxt;
        end
    end

endmodule : tick_lock_tracker

// File: rtl/tick_period_meter.sv
// Measures the cycle distance between consecutive tick pulses, with timeout.
// Define TICK_PERIOD_LOCK_EN to include the period lock tracker.
module tick_period_meter
    import generator_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (LOCK_COUNT < 2) begin : g_lock_count_chk
        $error("tick_period_meter: LOCK_COUNT must be at least 2");
    end

    meas_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic             period_vld_nxt;
    logic             timeout_nxt;

    // Next-state and registered-output computation.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        period_nxt     = period;
        period_vld_nxt = 1'b0;
        timeout_nxt    = timeout;

        case (state)
            IDLE: begin
                if (tick) begin
                    cnt_nxt     = CNT_ONE;
                    timeout_nxt = 1'b0;
                    state_nxt   = MEAS;
                end
            end
            MEAS: begin
                if (tick) begin
                    period_nxt     = cnt;
                    period_vld_nxt = 1'b1;
                    cnt_nxt        = CNT_ONE;
                end else if (cnt == CNT_MAX) begin
                    // Saturated: reference lost, never wrap.
                    timeout_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = CNT_W'(cnt + CNT_ONE);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            period     <= period_nxt;
            period_vld <= period_vld_nxt;
            timeout    <= timeout_nxt;
        end
    end

`ifdef TICK_PERIOD_LOCK_EN
    // Fed with next-cycle values so locked moves together with period_vld.
    tick_lock_tracker #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock (
        .clk        (clk),
        .rst        (rst),
        .period     (period_nxt),
        .period_vld (period_vld_nxt),
        .timeout    (timeout_nxt && !timeout),
        .locked     (locked)
    );
`else
    assign locked = 1'b0;
`endif

endmodule : tick_period_meter

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter (CNT_W=4 so the timeout is reachable).
module tb_tick_period_meter;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned LOCK_COUNT = 4;
`ifdef TICK_PERIOD_LOCK_EN
    localparam logic LK = 1'b1;
`else
    localparam logic LK = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             timeout;

    int n_cmp;
    int n_err;

    tick_period_meter #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .period     (period),
        .period_vld (period_vld),
        .locked     (locked),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of tick, then check outputs just after the edge.
    task automatic step(input logic t, input logic [CNT_W-1:0] ep, input logic ev,
                        input logic el, input logic eto, input string tag);
        tick = t;
        @(posedge clk);
        #1;
        chk({tag, ".period"},     32'(period),     32'(ep));
        chk({tag, ".period_vld"}, 32'(period_vld), 32'(ev));
        chk({tag, ".locked"},     32'(locked),     32'(el));
        chk({tag, ".timeout"},    32'(timeout),    32'(eto));
    endtask

    task automatic gap(input int n, input logic [CNT_W-1:0] ep, input logic el,
                       input logic eto, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, ep, 1'b0, el, eto, tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, tag);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, tag);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        tick  = 1'b0;

        do_reset("reset");

        // Ticks every 3 cycles
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "p3_arm");
        gap(2, 4'd0, 1'b0, 1'b0, "p3_gap0");
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, "p3_s1");
        gap(2, 4'd3, 1'b0, 1'b0, "p3_gap1");
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, "p3_s2");
        step(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, "p3_after");

        // Back-to-back ticks
        do_reset("rst_b2b");
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "b2b_arm");
        step(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, "b2b_s1");
        step(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, "b2b_s2");
        step(1'b0, 4'd1, 1'b0, 1'b0, 1'b0, "b2b_after");

        // Ticks at 0,5,10,15,20 then 26: lock then unlock
        do_reset("rst_lock");
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "lk_arm");
        gap(4, 4'd0, 1'b0, 1'b0, "lk_gap0");
        step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, "lk_s1");
        gap(4, 4'd5, 1'b0, 1'b0, "lk_gap1");
        step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, "lk_s2");
        gap(4, 4'd5, 1'b0, 1'b0, "lk_gap2");
        step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, "lk_s3");
        gap(4, 4'd5, 1'b0, 1'b0, "lk_gap3");
        step(1'b1, 4'd5, 1'b1, LK, 1'b0, "lk_s4");
        gap(5, 4'd5, LK, 1'b0, "lk_hold");
        step(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, "lk_s5_unlock");
        step(1'b0, 4'd6, 1'b0, 1'b0, 1'b0, "lk_after");

        // Timeout at saturation, then tick at exactly max period
        do_reset("rst_to");
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "to_arm");
        gap(2, 4'd0, 1'b0, 1'b0, "to_gap0");
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, "to_s1");
        gap(14, 4'd3, 1'b0, 1'b0, "to_count");
        step(1'b0, 4'd3, 1'b0, 1'b0, 1'b1, "to_fire");
        gap(3, 4'd3, 1'b0, 1'b1, "to_hold");
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, "to_rearm");
        gap(14, 4'd3, 1'b0, 1'b0, "to_count2");
        step(1'b1, 4'd15, 1'b1, 1'b0, 1'b0, "to_max_period");
        step(1'b0, 4'd15, 1'b0, 1'b0, 1'b0, "to_after");

        // Lock, then timeout drops lock; first measurement after IDLE does not match
        do_reset("rst_lkto");
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "lt_arm");
        gap(2, 4'd0, 1'b0, 1'b0, "lt_gap0");
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, "lt_s1");
        gap(2, 4'd3, 1'b0, 1'b0, "lt_gap1");
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, "lt_s2");
        gap(2, 4'd3, 1'b0, 1'b0, "lt_gap2");
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, "lt_s3");
        gap(2, 4'd3, 1'b0, 1'b0, "lt_gap3");
        step(1'b1, 4'd3, 1'b1, LK, 1'b0, "lt_s4");
        gap(14, 4'd3, LK, 1'b0, "lt_count");
        step(1'b0, 4'd3, 1'b0, 1'b0, 1'b1, "lt_timeout");
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, "lt_rearm");
        gap(2, 4'd3, 1'b0, 1'b0, "lt_gap4");
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, "lt_first_after_idle");

        // Reset mid-measurement with a coincident tick
        do_reset("rst_mid");
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "rm_arm");
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "rm_gap0");
        step(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, "rm_s1");
        step(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, "rm_gap1");
        rst = 1'b1;
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "rm_reset");
        rst = 1'b0;
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "rm_rearm");
        gap(3, 4'd0, 1'b0, 1'b0, "rm_gap2");
        step(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, "rm_s2");
        step(1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "rm_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tick_period_meter
